// File: rtl/pipelined_adder_sub_if.sv
// Handshake and operand/result bundle for the pipelined adder/subtractor.
// The master is the producer/consumer side; the slave is the adder itself.
interface pipelined_adder_sub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_adder_sub.sv
// WIDTH-bit adder/subtractor resolving one SEG_W-bit segment per pipeline stage,
// with the carry rippling between stages through registers and valid/ready flow control.
module pipelined_adder_sub #(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4
) (
    input logic                  clk,
    input logic                  rst,
    pipelined_adder_sub_if.slave bus
);
    localparam int STAGES = WIDTH / SEG_W;

    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             stall;
    logic             in_ready;
    logic             accept;
    logic             out_valid;

    // Subtraction is a + ~b + 1, so the forced carry-in replaces cin.
    assign b_eff    = bus.sub ? ~bus.b : bus.b;
    assign c0       = bus.sub | bus.cin;
    assign stall    = out_valid && !bus.out_ready;
    assign in_ready = !rst && !stall;
    assign accept   = bus.in_valid && in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int IN_W  = WIDTH - gi * SEG_W;
            localparam int OUT_W = (gi + 1) * SEG_W;

            logic [IN_W-1:0]  a_in;
            logic [IN_W-1:0]  b_in;
            logic             c_in;
            logic             v_in;
            logic [SEG_W:0]   seg_sum;
            logic [OUT_W-1:0] res_d;
            logic [OUT_W-1:0] res_q;
            logic             carry_q;
            logic             valid_q;

            // Operands arrive right-aligned: the segment for this stage sits in the low bits.
            if (gi == 0) begin : g_src
                assign a_in  = bus.a;
                assign b_in  = b_eff;
                assign c_in  = c0;
                assign v_in  = accept;
                assign res_d = seg_sum[SEG_W-1:0];
            end else begin : g_src
                assign a_in  = g_stage[gi-1].g_rem.a_rem_q;
                assign b_in  = g_stage[gi-1].g_rem.b_rem_q;
                assign c_in  = g_stage[gi-1].carry_q;
                assign v_in  = g_stage[gi-1].valid_q;
                assign res_d = {seg_sum[SEG_W-1:0], g_stage[gi-1].res_q};
            end

            assign seg_sum = {1'b0, a_in[SEG_W-1:0]} + {1'b0, b_in[SEG_W-1:0]}
                           + {{SEG_W{1'b0}}, c_in};

            // Data only loads with a real beat so outputs hold their value across bubbles.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    carry_q <= 1'b0;
                    res_q   <= '0;
                end else if (!stall) begin
                    valid_q <= v_in;
                    if (v_in) begin
                        carry_q <= seg_sum[SEG_W];
                        res_q   <= res_d;
                    end
                end
            end

            if (gi < STAGES - 1) begin : g_rem
                logic [IN_W-SEG_W-1:0] a_rem_q;
                logic [IN_W-SEG_W-1:0] b_rem_q;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        a_rem_q <= '0;
                        b_rem_q <= '0;
                    end else if (!stall && v_in) begin
                        a_rem_q <= a_in[IN_W-1:SEG_W];
                        b_rem_q <= b_in[IN_W-1:SEG_W];
                    end
                end
            end else begin : g_msb
                // The last segment still carries the operand sign bits needed for overflow.
                logic a_msb_q;
                logic b_msb_q;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        a_msb_q <= 1'b0;
                        b_msb_q <= 1'b0;
                    end else if (!stall && v_in) begin
                        a_msb_q <= a_in[IN_W-1];
                        b_msb_q <= b_in[IN_W-1];
                    end
                end
            end
        end
    endgenerate

    assign out_valid     = g_stage[STAGES-1].valid_q;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.sum       = g_stage[STAGES-1].res_q;
    assign bus.cout      = g_stage[STAGES-1].carry_q;
    assign bus.ovf       = (g_stage[STAGES-1].g_msb.a_msb_q == g_stage[STAGES-1].g_msb.b_msb_q)
                        && (g_stage[STAGES-1].res_q[WIDTH-1] != g_stage[STAGES-1].g_msb.a_msb_q);
endmodule
